// File: rtl/arbiter_wrr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbiter_wrr_if : request/weight/grant bundle for the WRR arbiter          |
// | Revision 1.0 ; optional lock signal under ARBITER_WRR_LOCK_EN             |
// +--------------------------------------------------------------------------+
interface arbiter_wrr_if #(
  parameter int NUM_PORTS    = 9,
  parameter int WEIGHT_WIDTH = 4,
  parameter int SEL_WIDTH    = 4
);
  logic [0:NUM_PORTS-1]              request;
  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight;
  logic [0:NUM_PORTS-1]              grant;
  logic [SEL_WIDTH-1:0]              grant_id;
  logic                              active;
`ifdef ARBITER_WRR_LOCK_EN
  logic                              lock;

  modport master (output request, weight, lock, input grant, grant_id, active);
  modport slave  (input request, weight, lock, output grant, grant_id, active);
`else
  modport master (output request, weight, input grant, grant_id, active);
  modport slave  (input request, weight, output grant, grant_id, active);
`endif
endinterface
`default_nettype wire

// File: rtl/arbiter_wrr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbiter_wrr : weighted round-robin arbiter, registered one-hot grant      |
// | Revision 1.0 ; optional hold input under ARBITER_WRR_LOCK_EN              |
// +--------------------------------------------------------------------------+
module arbiter_wrr #(
  parameter int NUM_PORTS    = 9,
  parameter int WEIGHT_WIDTH = 4,
  parameter int SEL_WIDTH    = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  arbiter_wrr_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [0:NUM_PORTS-1]    grant_q, grant_d;
  logic [SEL_WIDTH-1:0]    grant_id_q, grant_id_d;
  logic                    active_q, active_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [SEL_WIDTH-1:0]    last_q, last_d;

  logic                    lock_in;
  logic                    idle_hit, next_hit;
  logic [SEL_WIDTH-1:0]    idle_idx, next_idx;
  logic [SEL_WIDTH-1:0]    idle_start, next_start;
  logic [WEIGHT_WIDTH-1:0] w_g, ew_g;
  logic                    req_g;

`ifdef ARBITER_WRR_LOCK_EN
  assign lock_in = bus.lock;
`else
  assign lock_in = 1'b0;
`endif

  // First requester at or after start, measured by circular distance.
  function automatic void find_from(
    input  logic [0:NUM_PORTS-1] req,
    input  logic [SEL_WIDTH-1:0] start,
    output logic                 hit,
    output logic [SEL_WIDTH-1:0] idx
  );
    int s, d, best;
    s    = int'(start);
    best = NUM_PORTS;
    hit  = 1'b0;
    idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i]) begin
        d = (i >= s) ? (i - s) : (i + NUM_PORTS - s);
        if (d < best) begin
          best = d;
          hit  = 1'b1;
          idx  = SEL_WIDTH'(i);
        end
      end
    end
  endfunction

  assign idle_start = (last_q == SEL_WIDTH'(NUM_PORTS-1)) ? '0 : last_q + SEL_WIDTH'(1);
  assign next_start = (grant_id_q == SEL_WIDTH'(NUM_PORTS-1)) ? '0 : grant_id_q + SEL_WIDTH'(1);
  assign req_g      = |(bus.request & grant_q);
  assign ew_g       = (w_g == '0) ? WEIGHT_WIDTH'(1) : w_g;

  always_comb begin
    w_g = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id_q == SEL_WIDTH'(i)) w_g = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  always_comb begin
    find_from(bus.request, idle_start, idle_hit, idle_idx);
    find_from(bus.request, next_start, next_hit, next_idx);
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    credit_d   = credit_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (idle_hit) begin
          state_d    = GRANT;
          grant_id_d = idle_idx;
          credit_d   = WEIGHT_WIDTH'(1);
        end
      end
      GRANT: begin
        if (!req_g) begin
          last_d = grant_id_q;
          if (next_hit) begin
            grant_id_d = next_idx;
            credit_d   = WEIGHT_WIDTH'(1);
          end else begin
            state_d    = IDLE;
            grant_id_d = '0;
            credit_d   = '0;
          end
        end else if (lock_in) begin
          credit_d = (credit_q >= ew_g) ? ew_g : credit_q + WEIGHT_WIDTH'(1);
        end else if (credit_q < ew_g) begin
          credit_d = credit_q + WEIGHT_WIDTH'(1);
        end else begin
          // Quantum spent; the search may wrap back to g when it is alone.
          last_d     = grant_id_q;
          grant_id_d = next_idx;
          credit_d   = WEIGHT_WIDTH'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        grant_id_d = '0;
        credit_d   = '0;
      end
    endcase

    active_d = (state_d == GRANT);
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_d[i] = (state_d == GRANT) && (grant_id_d == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      active_q   <= 1'b0;
      credit_q   <= '0;
      last_q     <= SEL_WIDTH'(NUM_PORTS-1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      active_q   <= active_d;
      credit_q   <= credit_d;
      last_q     <= last_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.active   = active_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_wrr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arbiter_wrr : directed and random checks against a behavioural model   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_arbiter_wrr;
  localparam int N  = 9;
  localparam int WW = 4;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  arbiter_wrr_if #(.NUM_PORTS(N), .WEIGHT_WIDTH(WW), .SEL_WIDTH(SW)) bus ();

  arbiter_wrr #(.NUM_PORTS(N), .WEIGHT_WIDTH(WW), .SEL_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ARBITER_WRR_LOCK_EN
  initial bus.lock = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: current owner (-1 idle), cycles used in quantum, previous owner.
  int m_cur  = -1;
  int m_used = 0;
  int m_last = N - 1;

  function automatic int ew(int i);
    int w;
    w = int'(bus.weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int search(int start);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start + k) % N;
      if (bus.request[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cur  = -1;
    m_used = 0;
    m_last = N - 1;
  endtask

  task automatic model_edge();
    if (m_cur < 0) begin
      m_cur = search((m_last + 1) % N);
      m_used = 1;
    end else if (!bus.request[m_cur]) begin
      m_last = m_cur;
      m_cur  = search(m_cur + 1);
      m_used = 1;
    end else if (m_used < ew(m_cur)) begin
      m_used++;
    end else begin
      m_last = m_cur;
      m_cur  = search(m_cur + 1);
      m_used = 1;
    end
  endtask

  task automatic check(string tag);
    logic [0:N-1]  eg;
    logic [SW-1:0] eid;
    eg  = '0;
    eid = '0;
    if (m_cur >= 0) begin
      eg[m_cur] = 1'b1;
      eid = SW'(m_cur);
    end
    n_chk++;
    assert (bus.grant === eg) else begin
      n_fail++;
      $error("FAIL %s grant got %b expected %b", tag, bus.grant, eg);
    end
    n_chk++;
    assert (bus.grant_id === eid) else begin
      n_fail++;
      $error("FAIL %s grant_id got %0d expected %0d", tag, bus.grant_id, eid);
    end
    n_chk++;
    assert (bus.active === (m_cur >= 0)) else begin
      n_fail++;
      $error("FAIL %s active got %b expected %b", tag, bus.active, (m_cur >= 0));
    end
  endtask

  task automatic step(string tag, int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_edge();
      #1;
      check(tag);
    end
  endtask

  task automatic set_all_weights(int w);
    for (int i = 0; i < N; i++) bus.weight[i*WW +: WW] = WW'(w);
  endtask

  initial begin
    logic [31:0] rnd;
    bus.request = '1;
    set_all_weights(1);
    model_reset();

    // Held in reset with every port requesting
    step("reset", 10);
    rst = 1'b1;
    step("first_grant", 1);

    bus.request = 9'b100000001;
    step("alt_w1", 8);

    bus.weight[0*WW +: WW] = 4'd3;
    bus.weight[8*WW +: WW] = 4'd1;
    step("w3_w1", 12);

    set_all_weights(1);
    bus.weight[1*WW +: WW] = 4'd2;
    bus.request = 9'b010000000;
    step("single", 15);
    bus.request = '0;
    step("drop", 2);

    bus.weight[0*WW +: WW] = 4'd5;
    bus.request = 9'b100000001;
    for (int k = 0; k < 20 && m_cur != 0; k++) step("wait_p0", 1);
    step("early_hold", 2);
    bus.request = 9'b000000001;
    step("early_rel", 3);

    set_all_weights(0);
    bus.request = '1;
    step("rot_w0", 13);
    #2 rst = 1'b0;
    model_reset();
    #1 check("async_rst");
    step("in_rst", 2);
    rst = 1'b1;
    step("after_rst", 12);

    for (int c = 0; c < 400; c++) begin
      rnd = $urandom;
      if (rnd[31:29] == 3'd0) bus.request = '0;
      else if (rnd[28]) bus.request = N'($urandom);
      else if (rnd[27]) bus.request[rnd[3:0] % N] = ~bus.request[rnd[3:0] % N];
      if (rnd[26:24] == 3'd0) bus.weight = (N*WW)'({$urandom, $urandom});
      step("random", 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
